// File: rtl/aes128_wordio.sv
// Iterative AES-128 encryptor: 8-word serial load, one round per clock, 4-word serial readout.
// Optional macro AES_OUT_CLEAR_EN forces dword_out to zero outside the four readout cycles.
module aes128_wordio (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_n,
  input  logic        start_read_n,
  input  logic [31:0] dword_in,
  output logic [31:0] dword_out,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DONE, READ} state_t;

  // S-box entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [3:0]     round_q, round_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   key_q, key_d;
  logic [31:0]    dout_q, dout_d;
  logic           done_q, done_d;

  logic [127:0]   sb, sr, mc, rk, round_out;
  logic [31:0]    temp;

  // Round datapath: state byte b is row b%4, column b/4.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int b = 0; b < 16; b++) begin
      sb[127-8*b -: 8] = sbox(data_q[127-8*b -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
    end
    temp = {sbox(key_q[23:16]), sbox(key_q[15:8]), sbox(key_q[7:0]), sbox(key_q[31:24])}
           ^ {rcon(round_q), 24'h0};
    rk[127:96] = key_q[127:96] ^ temp;
    rk[95:64]  = key_q[95:64]  ^ rk[127:96];
    rk[63:32]  = key_q[63:32]  ^ rk[95:64];
    rk[31:0]   = key_q[31:0]   ^ rk[63:32];
    round_out  = ((round_q == 4'd10) ? sr : mc) ^ rk;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    data_d  = data_q;
    key_d   = key_q;
    done_d  = done_q;
`ifdef AES_OUT_CLEAR_EN
    dout_d  = '0;
`else
    dout_d  = dout_q;
`endif
    case (state_q)
      IDLE: begin
        if (!start_n) begin
          data_d  = {data_q[95:0], dword_in};
          cnt_d   = 3'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q < 3'd4) data_d = {data_q[95:0], dword_in};
        else              key_d  = {key_q[95:0], dword_in};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          round_d = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (round_q == 4'd0) begin
          data_d = data_q ^ key_q;
        end else begin
          data_d = round_out;
          key_d  = rk;
        end
        if (round_q == 4'd10) begin
          round_d = 4'd0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        // Readout takes priority over a restart.
        if (!start_read_n) begin
          done_d  = 1'b0;
          dout_d  = data_q[127:96];
          data_d  = {data_q[95:0], 32'h0};
          cnt_d   = 3'd1;
          state_d = READ;
        end else if (!start_n) begin
          done_d  = 1'b0;
          data_d  = {data_q[95:0], dword_in};
          cnt_d   = 3'd1;
          state_d = LOAD;
        end
      end
      READ: begin
        dout_d = data_q[127:96];
        data_d = {data_q[95:0], 32'h0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      data_q  <= '0;
      key_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      data_q  <= data_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign dword_out = dout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_wordio.sv
// Directed known-answer bench for aes128_wordio: vector table plus restart and reset corner cases.
module tb_aes128_wordio;

  logic        clk;
  logic        reset;
  logic        start_n;
  logic        start_read_n;
  logic [31:0] dword_in;
  logic [31:0] dword_out;
  logic        done;

  aes128_wordio dut (
    .clk          (clk),
    .reset        (reset),
    .start_n      (start_n),
    .start_read_n (start_read_n),
    .dword_in     (dword_in),
    .dword_out    (dword_out),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    bit           noise;
    bit           both;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] GF_PT  = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
  localparam logic [127:0] GF_CT  = 128'h0336763e966d92595a567cc9ce537f5e;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] last_out;
  vec_t        vecs[4];

  function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  function automatic logic [31:0] idle_out(input logic [31:0] held);
`ifdef AES_OUT_CLEAR_EN
    return 32'h0;
`else
    return held;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start edge plus seven more load edges; optional strobe noise during LOAD.
  task automatic send_words(input logic [127:0] pt, input logic [127:0] key, input bit noise);
    start_n  = 1'b0;
    dword_in = word_of(pt, 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (k == 1) check("done_low_after_start", {31'h0, done}, 32'h0);
      start_n      = (noise && k[0]) ? 1'b0 : 1'b1;
      start_read_n = (noise && !k[0]) ? 1'b0 : 1'b1;
      dword_in     = (k < 4) ? word_of(pt, k) : word_of(key, k - 4);
    end
    tick();
    start_n      = 1'b1;
    start_read_n = 1'b1;
  endtask

  task automatic wait_done(input bit noise);
    int lat;
    lat = 0;
    while (!done && lat < 30) begin
      start_n      = (noise && lat < 9) ? lat[0] : 1'b1;
      start_read_n = (noise && lat < 9) ? ~lat[0] : 1'b1;
      tick();
      lat++;
    end
    start_n      = 1'b1;
    start_read_n = 1'b1;
    check("done_latency", lat, 11);
    check("dout_before_read", dword_out, idle_out(last_out));
  endtask

  task automatic run_read(input logic [127:0] ct, input bit both);
    start_read_n = 1'b0;
    start_n      = both ? 1'b0 : 1'b1;
    tick();
    start_read_n = 1'b1;
    start_n      = 1'b1;
    check("done_falls_on_read", {31'h0, done}, 32'h0);
    check("ct_word0", dword_out, word_of(ct, 0));
    for (int k = 1; k < 4; k++) begin
      tick();
      check("ct_word", dword_out, word_of(ct, k));
    end
    last_out = word_of(ct, 3);
    tick();
    check("dout_after_read", dword_out, idle_out(last_out));
    check("done_low_after_read", {31'h0, done}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{pt: C1_PT, key: C1_KEY, ct: C1_CT, noise: 1'b0, both: 1'b0};
    vecs[1] = '{pt: GF_PT, key: 128'h0, ct: GF_CT, noise: 1'b0, both: 1'b0};
    vecs[2] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, noise: 1'b1, both: 1'b0};
    vecs[3] = '{pt: 128'h0, key: 128'h0,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, noise: 1'b0, both: 1'b1};

    reset        = 1'b1;
    start_n      = 1'b1;
    start_read_n = 1'b1;
    dword_in     = 32'h0;
    last_out     = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_dout", dword_out, 32'h0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].noise) begin
        start_read_n = 1'b0;
        tick();
        start_read_n = 1'b1;
        check("idle_read_ignored_done", {31'h0, done}, 32'h0);
        check("idle_read_ignored_dout", dword_out, idle_out(last_out));
      end
      send_words(vecs[v].pt, vecs[v].key, vecs[v].noise);
      wait_done(vecs[v].noise);
      run_read(vecs[v].ct, vecs[v].both);
    end

    // Restart from DONE without reading: first result must be discarded.
    send_words(GF_PT, 128'h0, 1'b0);
    wait_done(1'b0);
    send_words(C1_PT, C1_KEY, 1'b0);
    wait_done(1'b0);
    run_read(C1_CT, 1'b0);

    // Reset during round 5 of CALC.
    send_words(C1_PT, C1_KEY, 1'b0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_out = 32'h0;
    check("midcalc_reset_done", {31'h0, done}, 32'h0);
    check("midcalc_reset_dout", dword_out, 32'h0);
    repeat (15) tick();
    check("no_done_after_abort", {31'h0, done}, 32'h0);
    send_words(C1_PT, C1_KEY, 1'b0);
    wait_done(1'b0);
    run_read(C1_CT, 1'b0);
    repeat (3) tick();
    check("dout_holds_idle", dword_out, idle_out(32'h70b4c55a));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes128_wordio.md
Name: aes128_wordio

Overview:
- Iterative AES-128 encryption core (FIPS-197) with a 32-bit word-serial load/unload interface.
- Loads a 128-bit plaintext and then a 128-bit key as 8 consecutive 32-bit words.
- Computes one round per clock, raises done, then streams the 128-bit ciphertext out as 4 words on request.
- Standalone crypto leaf, driven by a host controller or bus adapter.

Parameters:
- None. Block size and key size are fixed at 128; 10 rounds.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start_n  input  1  active-low start strobe; the word on dword_in in the same cycle is plaintext word 0
- start_read_n  input  1  active-low strobe to begin ciphertext readout
- dword_in  input  32  plaintext/key load word
- dword_out  output  32  ciphertext readout word
- done  output  1  high when the ciphertext is ready and has not yet been read

Behaviour:
- Word order: word 0 = bits [127:96] through word 3 = bits [31:0]. Bytes map to the state column-major per FIPS-197, so word i is state column i.
- Reset (reset high at a rising edge):
  - state = IDLE, done = 0, dword_out = 0.
  - Word counter, round counter, state register and key register cleared.
  - Reset mid-operation aborts everything; the result is lost.
- States: IDLE, LOAD, CALC, DONE, READ.
- IDLE:
  - At an edge with start_n = 0: capture dword_in as PT word 0, go to LOAD with count = 1.
- LOAD (start_n ignored):
  - Captures dword_in at each edge: PT words 1-3 on the next 3 edges, then key words 0-3 on the following 4 edges. Load is 8 consecutive edges total, no stalls.
  - After key word 3 is captured, go to CALC.
- CALC:
  - 11 edges. Edge 1: state ^= key (round 0 AddRoundKey). Edges 2-11: rounds 1-10.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
  - Round keys are expanded on the fly, one per round, using Rcon 01,02,04,08,10,20,40,80,1b,36.
  - On edge 11, done becomes 1 and the state goes to DONE.
  - Latency: done visible 11 cycles after the edge that captured key word 3; 19 edges after the start edge inclusive.
- DONE:
  - done holds 1 indefinitely.
  - start_read_n = 0 at an edge: done falls to 0, dword_out = CT word 0, go to READ.
  - start_n = 0 (with start_read_n = 1): the result is discarded, done falls to 0, dword_in is captured as PT word 0, go to LOAD.
  - Both strobes low in the same cycle: the read wins.
- READ:
  - The next 3 edges drive dword_out = CT words 1, 2, 3; the edge that drives word 3 returns to IDLE.
  - Both strobes are ignored during READ.
  - dword_out holds word 3 after READ until the next read (default build).
- start_read_n is ignored outside DONE. start_n is ignored outside IDLE and DONE.
- Combinational S-box: 256-entry constant table, 16 parallel instances plus 4 for key expansion.
- MixColumns uses xtime over GF(2^8), polynomial 0x11b.

Optional Feature:
- Macro: AES_OUT_CLEAR_EN.
- Defined: dword_out is driven 0 in every cycle except the 4 readout cycles. It is 0 again on the edge after CT word 3 was presented, once back in IDLE.
- Undefined: dword_out holds its last driven value outside READ (default).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff.
  - done rises exactly 11 cycles after key word 3.
  - Read gives 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- GFSbox KAT: key all zeros, PT f34481ec3cc627bacd5dc3fb08f273e6 -> CT words 0336763e, 966d9259, 5a567cc9, ce537f5e.
- Back-to-back: the second encryption starts in DONE without a read (start_n low) -> the first result is discarded, the second result is correct, and done stays low until the second CALC finishes.
- Reset asserted during CALC round 5 -> next cycle done = 0, dword_out = 0, IDLE.
  - A subsequent full C.1 run produces the correct ciphertext.
- Strobe hygiene:
  - start_n pulses during LOAD/CALC and start_read_n during IDLE/LOAD/CALC have no effect.
  - Both strobes low in DONE -> readout occurs.
- With AES_OUT_CLEAR_EN: dword_out = 0 during LOAD, CALC and DONE, and after readout. Without it, dword_out holds 70b4c55a after the C.1 readout.
